uart_mem_ctrl: RTL and testbench

UART_MEM_CTRL -- requirements
Module: uart_mem_ctrl

---
 rtl/uart_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_mem_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_ctrl.sv
// rtl/uart_mem_ctrl.sv - UART command interpreter driving a word-wide synchronous memory
module uart_mem_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 1024,
    parameter int CLK_DIV = 104
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_tx,
    output logic o_busy
);
    localparam int DB     = DATA_W / 8;
    localparam int AB     = (ADDR_W + 7) / 8;
    localparam int RESP_W = ((DB > AB) ? DB : AB) * 8;
    localparam int LW     = $clog2(RESP_W / 8 + 1);
    localparam int CW     = $clog2(CLK_DIV);
    localparam int MW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   BIT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   HALF     = CW'(CLK_DIV / 2 - 1);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, EXEC, RD_WAIT, TX_LOAD, TX_WAIT} state_t;

    logic            rx_s1, rx_s2, rx_prev;
    rx_state_t       rx_state, rx_next;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_byte;
    logic            rx_valid, rx_ferr;

    state_t          state, state_next;
    logic [7:0]      cmd;
    logic [3:0]      op;
    logic [DATA_W-1:0] data, mem_q;
    logic [ADDR_W-1:0] addr;
    logic            ferr, ovr, rerr;
    logic [RESP_W-1:0] resp_buf;
    logic [LW-1:0]   resp_left;
    logic            addr_ok, is_rd, mem_we, st_clr, rerr_set;
    logic [MW-1:0]   mem_idx;
    logic            tx_start, tx_ready, tx_active;
    logic [8:0]      tx_shift;
    logic [CW-1:0]   tx_cnt;
    logic [3:0]      tx_bit;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= i_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rx_state <= RX_IDLE;
        else       rx_state <= rx_next;
    end

    // A start bit that is high again at mid-bit is treated as a glitch
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_next = RX_START;
            RX_START: if (rx_cnt == HALF) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_cnt == BIT_LAST) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            if (rx_state == RX_IDLE || (rx_state == RX_START && rx_cnt == HALF) || rx_cnt == BIT_LAST)
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
                rx_byte <= {rx_s2, rx_byte[7:1]};
                rx_bit  <= rx_bit + 1'b1;
            end
            if (rx_state == RX_STOP && rx_cnt == BIT_LAST) begin
                rx_valid <= rx_s2;
                rx_ferr  <= !rx_s2;
            end
        end
    end

    assign op       = cmd[3:0];
    assign addr_ok  = {1'b0, addr} < DEPTH_L;
    assign is_rd    = (op == 4'h7) || (op == 4'h9);
    assign mem_idx  = addr[MW-1:0];
    assign mem_we   = (state == EXEC) && ((op == 4'h6) || (op == 4'h8)) && addr_ok;
    assign st_clr   = (state == EXEC) && (op == 4'h3);
    assign rerr_set = (state == EXEC) && ((op == 4'h6) || (op == 4'h8) || is_rd) && !addr_ok;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        o_busy     = (state != IDLE);
        case (state)
            IDLE:    if (rx_valid) state_next = EXEC;
            EXEC: begin
                if (op == 4'h1 || op == 4'h4) state_next = IDLE;
                else if (is_rd && addr_ok)    state_next = RD_WAIT;
                else                          state_next = TX_LOAD;
            end
            RD_WAIT: state_next = TX_LOAD;
            TX_LOAD: begin
                tx_start = 1'b1;
                if (tx_ready) state_next = TX_WAIT;
            end
            TX_WAIT: begin
                if (resp_left != '0) state_next = TX_LOAD;
                else if (!tx_active) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cmd       <= '0;
            data      <= '0;
            addr      <= '0;
            ferr      <= 1'b0;
            ovr       <= 1'b0;
            rerr      <= 1'b0;
            resp_buf  <= '0;
            resp_left <= '0;
        end else begin
            if (state == IDLE && rx_valid) cmd <= rx_byte;
            // A flag set in the same cycle as a status clear wins
            ferr <= (ferr & ~st_clr) | rx_ferr;
            ovr  <= (ovr  & ~st_clr) | (rx_valid && state != IDLE);
            rerr <= (rerr & ~st_clr) | rerr_set;
            if (state == EXEC) begin
                case (op)
                    4'h0: begin
                        resp_buf  <= RESP_W'(data);
                        resp_left <= LW'(DB);
                    end
                    4'h1: data <= DATA_W'({cmd[7:4], data} >> 4);
                    4'h2: begin
                        resp_buf  <= RESP_W'(addr);
                        resp_left <= LW'(AB);
                    end
                    4'h3: begin
                        resp_buf  <= RESP_W'({4'b0, ferr, ovr, rerr, 1'b1});
                        resp_left <= LW'(1);
                    end
                    4'h4: addr <= ADDR_W'({cmd[7:4], addr} >> 4);
                    4'h6, 4'h8: begin
                        resp_left <= LW'(1);
                        if (addr_ok) begin
                            resp_buf <= RESP_W'(8'h06);
                            if (op == 4'h8) addr <= addr + 1'b1;
                        end else begin
                            resp_buf <= RESP_W'(8'hE6);
                        end
                    end
                    4'h7, 4'h9: begin
                        if (!addr_ok) begin
                            resp_buf  <= RESP_W'(8'hE7);
                            resp_left <= LW'(1);
                        end
                    end
                    default: begin
                        resp_buf  <= RESP_W'(8'h3F);
                        resp_left <= LW'(1);
                    end
                endcase
            end
            if (state == RD_WAIT) begin
                data      <= mem_q;
                resp_buf  <= RESP_W'(mem_q);
                resp_left <= LW'(DB);
                if (op == 4'h9) addr <= addr + 1'b1;
            end
            if (tx_start && tx_ready) begin
                resp_buf  <= resp_buf >> 8;
                resp_left <= resp_left - 1'b1;
            end
        end
    end

    // Memory is deliberately outside the reset domain so its contents survive reset
    always_ff @(posedge i_clk) begin
        if (mem_we)  mem[mem_idx] <= data;
        if (addr_ok) mem_q <= mem[mem_idx];
    end

    // Accepting the next byte in the last stop-bit cycle keeps responses gap-free
    assign tx_ready = !tx_active || (tx_cnt == BIT_LAST && tx_bit == 4'd9);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_tx      <= 1'b1;
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_start && tx_ready) begin
            o_tx      <= 1'b0;
            tx_shift  <= {1'b1, resp_buf[7:0]};
            tx_active <= 1'b1;
            tx_cnt    <= '0;
            tx_bit    <= '0;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt   <= '0;
                o_tx     <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bit   <= tx_bit + 1'b1;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    o_tx      <= 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_mem_ctrl.sv
// tb/tb_uart_mem_ctrl.sv - directed and random command bench for uart_mem_ctrl
module tb_uart_mem_ctrl;
    localparam int CLK_DIV = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_rx  = 1'b1;
    logic o_tx, o_busy;

    uart_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .CLK_DIV(CLK_DIV)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_rx  (i_rx),
        .o_tx  (o_tx),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model of the command set
    logic [31:0] m_data, m_addr;
    logic [31:0] m_mem [1024];
    bit          m_wr  [1024];
    bit          m_ferr, m_ovr, m_rerr;
    logic [7:0]  exp_q[$], got_q[$], last_q[$];
    int          st_q[$];
    int          stop_cyc;

    function automatic void push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
    endfunction

    task automatic model_cmd(input logic [7:0] b);
        logic [3:0] op, nib;
        bit ok;
        op  = b[3:0];
        nib = b[7:4];
        ok  = (m_addr < 1024);
        case (op)
            4'h0: push_word(m_data);
            4'h1: m_data = {nib, m_data[31:4]};
            4'h2: push_word(m_addr);
            4'h3: begin
                exp_q.push_back({4'b0, m_ferr, m_ovr, m_rerr, 1'b1});
                m_ferr = 0; m_ovr = 0; m_rerr = 0;
            end
            4'h4: m_addr = {nib, m_addr[31:4]};
            4'h6, 4'h8: begin
                if (ok) begin
                    m_mem[m_addr[9:0]] = m_data;
                    m_wr[m_addr[9:0]]  = 1;
                    exp_q.push_back(8'h06);
                    if (op == 4'h8) m_addr = m_addr + 1;
                end else begin
                    m_rerr = 1;
                    exp_q.push_back(8'hE6);
                end
            end
            4'h7, 4'h9: begin
                if (ok) begin
                    m_data = m_mem[m_addr[9:0]];
                    push_word(m_data);
                    if (op == 4'h9) m_addr = m_addr + 1;
                end else begin
                    m_rerr = 1;
                    exp_q.push_back(8'hE7);
                end
            end
            default: exp_q.push_back(8'h3F);
        endcase
    endtask

    int         mon_t0;
    logic [7:0] mon_b;
    initial begin
        forever begin
            @(negedge i_clk);
            if (!o_tx && !i_rst) begin
                mon_t0 = cyc;
                repeat (CLK_DIV / 2) @(negedge i_clk);
                if (!o_tx) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (CLK_DIV) @(negedge i_clk);
                        mon_b[i] = o_tx;
                    end
                    repeat (CLK_DIV) @(negedge i_clk);
                    got_q.push_back(mon_b);
                    st_q.push_back(mon_t0);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            i_rx = fr[i];
            if (i == 9) stop_cyc = cyc;
            repeat (CLK_DIV - 1) @(negedge i_clk);
        end
        @(negedge i_clk);
        i_rx = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(negedge i_clk);
        while (o_busy && n < 100 * CLK_DIV) begin
            @(negedge i_clk);
            n++;
        end
        check("busy_timeout", o_busy, 0);
        repeat (4) @(negedge i_clk);
    endtask

    task automatic clear_caps();
        got_q.delete();
        st_q.delete();
        exp_q.delete();
    endtask

    task automatic check_resp(input string tag);
        last_q = got_q;
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        if (st_q.size() > 0)
            check({tag, "_lat"}, 32'((st_q[0] - stop_cyc) <= CLK_DIV / 2 + 8), 1);
        for (int i = 1; i < st_q.size(); i++)
            check({tag, "_gap"}, st_q[i] - st_q[i-1], 10 * CLK_DIV);
    endtask

    task automatic cmd(input logic [7:0] b);
        clear_caps();
        model_cmd(b);
        send_byte(b, 1'b1);
        wait_idle();
        check_resp($sformatf("op%02h", b));
    endtask

    task automatic load_data(input logic [31:0] v);
        for (int i = 0; i < 8; i++) cmd({v[4*i +: 4], 4'h1});
    endtask

    task automatic load_addr(input logic [31:0] v);
        for (int i = 0; i < 8; i++) cmd({v[4*i +: 4], 4'h4});
    endtask

    function automatic logic [31:0] last32();
        if (last_q.size() != 4) return 32'hxxxx_xxxx;
        return {last_q[3], last_q[2], last_q[1], last_q[0]};
    endfunction

    function automatic logic [31:0] last8();
        if (last_q.size() != 1) return 32'hxxxx_xxxx;
        return 32'(last_q[0]);
    endfunction

    initial begin
        logic [7:0] rb;
        int n, lows, sc;
        m_data = 0; m_addr = 0; m_ferr = 0; m_ovr = 0; m_rerr = 0;

        repeat (5) @(negedge i_clk);
        check("rst_tx", o_tx, 1);
        check("rst_busy", o_busy, 0);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        cmd(8'h00); check("rst_data", last32(), 32'h0);
        cmd(8'h02); check("rst_addr", last32(), 32'h0);
        cmd(8'h03); check("rst_flags", last8(), 8'h01);

        for (int i = 1; i <= 8; i++) cmd(8'((i << 4) | 1));
        cmd(8'h00); check("data_shift", last32(), 32'h8765_4321);

        load_data(32'hA000_0000);
        load_addr(32'h0000_03FF);
        cmd(8'h06); check("wr_top", last8(), 8'h06);
        load_data(32'h0);
        cmd(8'h07); check("rd_top", last32(), 32'hA000_0000);

        load_addr(32'hFF00_0000);
        cmd(8'h06); check("wr_oor", last8(), 8'hE6);
        cmd(8'h03); check("st_rerr", last8(), 8'h03);
        cmd(8'h03); check("st_clear", last8(), 8'h01);

        load_addr(32'h10);
        load_data(32'h1111_1111);
        cmd(8'h08); check("wr_inc0", last8(), 8'h06);
        load_data(32'h2222_2222);
        cmd(8'h08); check("wr_inc1", last8(), 8'h06);
        load_addr(32'h10);
        cmd(8'h09); check("rd_inc0", last32(), 32'h1111_1111);
        cmd(8'h09); check("rd_inc1", last32(), 32'h2222_2222);
        cmd(8'h02); check("addr_inc", last32(), 32'h12);

        clear_caps();
        model_cmd(8'h00);
        send_byte(8'h00, 1'b1);
        sc = stop_cyc;
        repeat (3 * CLK_DIV) @(negedge i_clk);
        send_byte(8'h11, 1'b1);
        m_ovr = 1;
        stop_cyc = sc;
        check("ovr_busy", o_busy, 1);
        wait_idle();
        check_resp("ovr_echo");
        check("ovr_echo_val", last32(), 32'h2222_2222);
        cmd(8'h03); check("st_ovr", last8(), 8'h05);

        clear_caps();
        send_byte(8'h00, 1'b0);
        m_ferr = 1;
        wait_idle();
        check_resp("ferr");
        cmd(8'h03); check("st_ferr", last8(), 8'h09);
        cmd(8'h05); check("bad_op", last8(), 8'h3F);

        for (int k = 0; k < 30; k++) begin
            rb = 8'($urandom);
            if (rb[3:0] == 4'h4 && $urandom_range(0, 1) == 1) rb[7:4] = 4'h0;
            if ((rb[3:0] == 4'h7 || rb[3:0] == 4'h9) && m_addr < 1024 && !m_wr[m_addr[9:0]])
                rb[3:0] = 4'h6;
            cmd(rb);
        end

        clear_caps();
        send_byte(8'h00, 1'b1);
        repeat (12 * CLK_DIV) @(negedge i_clk);
        n = 0;
        while (o_tx && n < 12 * CLK_DIV) begin
            @(negedge i_clk);
            n++;
        end
        check("mid_echo_low", o_tx, 0);
        i_rst = 1'b1;
        #1;
        check("mid_rst_tx_now", o_tx, 1);
        @(posedge i_clk);
        #1;
        check("mid_rst_tx", o_tx, 1);
        check("mid_rst_busy", o_busy, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        m_data = 0; m_addr = 0; m_ferr = 0; m_ovr = 0; m_rerr = 0;
        lows = 0;
        repeat (14 * CLK_DIV) begin
            @(negedge i_clk);
            if (!o_tx) lows++;
        end
        check("post_rst_quiet", lows, 0);
        cmd(8'h00); check("post_rst_data", last32(), 32'h0);
        load_addr(32'h0000_03FF);
        cmd(8'h07);
        load_addr(32'h10);
        cmd(8'h07);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
